// File: rtl/meter_sequencer.sv
// ---------------------------------------------------------------------------
// meter_sequencer: BCD parking-meter countdown with add/preset requests,
// 1 s prescaler and state-dependent display blanking.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module meter_sequencer #(
  parameter int TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  add_pulse,
  input  logic [1:0]  load_pulse,
  output logic [15:0] bcd_value,
  output logic        blank,
  output logic [1:0]  state,
  output logic        tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] LOW    = 2'b01;
  localparam logic [1:0] NORMAL = 2'b10;

  logic [CNT_W-1:0] cnt, next_cnt;
  logic             phase, next_phase;
  logic             slow_phase, next_slow;
  logic [15:0]      next_value;
  logic [15:0]      add_amount;
  logic [1:0]       next_state;
  logic             next_blank;

  // Digit-wise decimal add; any carry out of the top digit saturates.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum;
    logic        carry;
    logic [4:0]  d;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d     = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, carry};
      carry = (d > 5'd9);
      if (carry) d = d - 5'd10;
      sum[i*4 +: 4] = d[3:0];
    end
    return carry ? 16'h9999 : sum;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] a);
    logic [15:0] r;
    logic        borrow;
    r      = a;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (a[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = a[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick = (cnt == CNT_LAST);

  always_comb begin
    if (add_pulse[0])      add_amount = 16'h0060;
    else if (add_pulse[1]) add_amount = 16'h0120;
    else if (add_pulse[2]) add_amount = 16'h0180;
    else                   add_amount = 16'h0300;
  end

  always_comb begin
    next_cnt   = tick ? '0 : cnt + CNT_ONE;
    next_phase = phase ^ ((cnt == CNT_HALF) | tick);
    next_slow  = slow_phase ^ tick;
    next_value = bcd_value;
    if (|load_pulse) begin
      next_value = load_pulse[1] ? 16'h0205 : 16'h0010;
      next_cnt   = '0;
      next_phase = 1'b0;
      next_slow  = 1'b0;
    end else if (|add_pulse) begin
      next_value = bcd_add_sat(bcd_value, add_amount);
    end else if (tick && (bcd_value != 16'h0000)) begin
      next_value = bcd_dec(bcd_value);
    end
  end

  // Valid BCD orders like plain binary, so a hex compare gives the thresholds.
  always_comb begin
    if (next_value == 16'h0000)     next_state = EMPTY;
    else if (next_value < 16'h0200) next_state = LOW;
    else                            next_state = NORMAL;
    case (next_state)
      LOW:     next_blank = next_slow;
      EMPTY:   next_blank = next_phase;
      default: next_blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      phase      <= 1'b0;
      slow_phase <= 1'b0;
      bcd_value  <= 16'h0000;
      state      <= EMPTY;
      blank      <= 1'b0;
    end else begin
      cnt        <= next_cnt;
      phase      <= next_phase;
      slow_phase <= next_slow;
      bcd_value  <= next_value;
      state      <= next_state;
      blank      <= next_blank;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_meter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_meter_sequencer: queue-based scoreboard against an integer-seconds model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_meter_sequencer;

  localparam int TICK_DIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  add_pulse = '0;
  logic [1:0]  load_pulse = '0;
  logic [15:0] bcd_value;
  logic        blank;
  logic [1:0]  state;
  logic        tick;

  meter_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .add_pulse  (add_pulse),
    .load_pulse (load_pulse),
    .bcd_value  (bcd_value),
    .blank      (blank),
    .state      (state),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic [1:0]  st;
    logic        blk;
    logic        tk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: remaining time in whole seconds plus timing counters.
  int   m_value = 0;
  int   m_pc    = 0;
  bit   m_phase = 0;
  bit   m_slow  = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [1:0] classify(input int v);
    if (v == 0)       return 2'b00;
    else if (v < 200) return 2'b01;
    else              return 2'b10;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.bcd = to_bcd(m_value);
    e.st  = classify(m_value);
    e.blk = (e.st == 2'b01) ? m_slow : (e.st == 2'b00) ? m_phase : 1'b0;
    e.tk  = (m_pc == TICK_DIV - 1);
    return e;
  endfunction

  task automatic model_update(input logic r, input logic [3:0] a, input logic [1:0] l);
    bit t;
    int amt;
    t = (m_pc == TICK_DIV - 1);
    if (r) begin
      m_value = 0; m_pc = 0; m_phase = 0; m_slow = 0;
    end else if (l != 2'b00) begin
      m_value = l[1] ? 205 : 10;
      m_pc = 0; m_phase = 0; m_slow = 0;
    end else begin
      if (a != 4'b0000) begin
        amt = a[0] ? 60 : a[1] ? 120 : a[2] ? 180 : 300;
        m_value = (m_value + amt > 9999) ? 9999 : m_value + amt;
      end else if (t && m_value > 0) begin
        m_value = m_value - 1;
      end
      if (m_pc == TICK_DIV / 2 - 1 || t) m_phase = !m_phase;
      if (t) m_slow = !m_slow;
      m_pc = t ? 0 : m_pc + 1;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] a, input logic [1:0] l);
    @(posedge clk);
    #1;
    reset      = r;
    add_pulse  = a;
    load_pulse = l;
    q.push_back(model_outputs());
    model_update(r, a, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 2'b00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 4;
        if (bcd_value !== e.bcd) begin
          errors++;
          $display("FAIL bcd_value cycle %0d: got %h expected %h", cycle, bcd_value, e.bcd);
        end
        if (state !== e.st) begin
          errors++;
          $display("FAIL state cycle %0d: got %b expected %b", cycle, state, e.st);
        end
        if (blank !== e.blk) begin
          errors++;
          $display("FAIL blank cycle %0d: got %b expected %b", cycle, blank, e.blk);
        end
        if (tick !== e.tk) begin
          errors++;
          $display("FAIL tick cycle %0d: got %b expected %b", cycle, tick, e.tk);
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    logic [3:0] a;
    logic [1:0] l;
    repeat (2) @(posedge clk);
    model_update(1'b1, 4'b0000, 2'b00);

    // Short preset counts down to empty and holds, with blink at 0.5 s.
    step(1'b0, 4'b0000, 2'b01);
    idle(140);

    // Long preset crosses NORMAL->LOW, then slow blink.
    step(1'b0, 4'b0000, 2'b10);
    idle(100);

    // Adds up to saturation.
    step(1'b0, 4'b0000, 2'b10);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1000, 2'b00);
    for (int i = 0; i < 150; i++) step(1'b0, 4'b0001, 2'b00);

    // Add coinciding with tick at 9999: no decrement.
    for (int i = 0; i < TICK_DIV && m_pc != TICK_DIV - 1; i++) idle(1);
    step(1'b0, 4'b0011, 2'b00);
    idle(3);
    step(1'b0, 4'b0100, 2'b11);
    idle(3);

    // Run to empty, observe blink, then reset swallows a coincident add.
    step(1'b0, 4'b0000, 2'b01);
    idle(120);
    step(1'b1, 4'b0001, 2'b00);
    idle(5);

    // Mid-countdown reset.
    step(1'b0, 4'b0000, 2'b10);
    idle(23);
    step(1'b1, 4'b0000, 2'b00);
    idle(4);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      l = ($urandom_range(0, 149) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(r < 2, a, l);
    end
    step(1'b0, 4'b0000, 2'b00);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/meter_sequencer.md
METER_SEQUENCER -- requirements
Module: meter_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per 1 s countdown tick; even, >=4.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port add_pulse  input  4  one-cycle debounced add requests; bit0 +60, bit1 +120, bit2 +180, bit3 +300 (seconds).
REQ-005 SHALL have port load_pulse  input  2  one-cycle preset requests; bit0 load 0010, bit1 load 0205.
REQ-006 SHALL have port bcd_value  output  16  remaining time, 4 BCD digits, [15:12] most significant.
REQ-007 SHALL have port blank  output  1  display blank request; 1 = display shows nothing this cycle.
REQ-008 SHALL have port state  output  2  meter state: 00 EMPTY, 01 LOW, 10 NORMAL.
REQ-009 SHALL have port tick  output  1  one-cycle pulse at each 1 s boundary.

Function
REQ-010 SHALL run a prescaler counting 0..TICK_DIV-1 and wrapping; tick = 1 in the cycle the count equals TICK_DIV-1.
REQ-011 SHALL keep a phase bit that toggles when the count equals TICK_DIV/2-1 and when it equals TICK_DIV-1, giving a 1 Hz square wave.
REQ-012 SHALL also keep a slow-phase bit that toggles on every tick, giving a 0.5 Hz square wave.
REQ-013 SHALL, on load_pulse, set bcd_value to 0010 (bit0) or 0205 (bit1); bit1 wins if both are set; it SHALL also clear the prescaler and both phase bits.
REQ-014 SHALL, on add_pulse with no load_pulse, add the amount for the lowest set bit only, in BCD with decimal carry, saturating at 9999.
REQ-015 SHALL, on tick with no load_pulse or add_pulse, decrement bcd_value by 1 in BCD with decimal borrow (e.g. 0100 -> 0099); at 0000 it SHALL hold 0000.
REQ-016 Priority SHALL be load > add > tick; when add and tick coincide, the decrement for that second SHALL be dropped, not deferred.
REQ-017 Every update SHALL take effect on bcd_value exactly one cycle after the request cycle; no request SHALL be queued.
REQ-018 state SHALL be a registered function of the next bcd_value, updated in the same cycle as bcd_value:
 - EMPTY when the value is 0000;
 - LOW for 0001..0199;
 - NORMAL for >=0200.
REQ-019 State transitions SHALL follow the value:
 - NORMAL->LOW on a decrement from 0200 to 0199;
 - LOW->EMPTY on a decrement from 0001;
 - any state to LOW or NORMAL on add or load, per REQ-018.
REQ-020 blank SHALL be registered as follows:
 - NORMAL: 0;
 - LOW: equal to slow-phase (display on 1 s, off 1 s);
 - EMPTY: equal to phase (display on 0.5 s, off 0.5 s).
REQ-021 Every intermediate BCD digit SHALL stay within 0..9; no non-BCD code SHALL ever appear on bcd_value.
REQ-022 The prescaler SHALL free-run in all states, including EMPTY.

Reset
REQ-023 On reset, the block SHALL set:
 - bcd_value = 0000, state = EMPTY;
 - blank = 0, tick = 0;
 - prescaler = 0, phase = 0, slow-phase = 0.
REQ-024 Reset SHALL override any coincident load_pulse or add_pulse; the pulse SHALL be lost.
REQ-025 Reset asserted mid-countdown SHALL take effect on the next edge, with no partial update.

Verification (TICK_DIV=10)
REQ-026 Reset, then load_pulse=01 -> bcd_value 0010 and state LOW next cycle; after 10 ticks -> 0000, EMPTY; further ticks hold 0000.
REQ-027 Load 0205, then 6 ticks -> 0199 and state NORMAL->LOW at the 0200->0199 step; blank then toggles every 10 cycles.
REQ-028 Load 0205, then add_pulse=1000 four times, then add_pulse=0001 repeatedly -> value reaches 1405, ..., and saturates at 9999.
REQ-029 Hold 9999, drive add_pulse=0011 coinciding with tick -> remains 9999 with no decrement; load_pulse=11 with add_pulse=0100 -> 0205.
REQ-030 In EMPTY, blank toggles every 5 cycles; assert reset while add_pulse=0001 -> 0000, EMPTY, blank=0, add lost.
